uart_io_txbuf: RTL

- CPU-side console output buffer, directly upstream of the UART monitor top.
- Accepts memory-mapped byte writes from the CPU I/O space into a FIFO.
- Drains the FIFO into the monitor's uart_io_char/uart_io_we/uart_io_full character port, with optional LF to CR-LF expansion.
- Exposes status/control registers so firmware can poll occupancy, flush, and detect overrun.

---
 rtl/uart_io_txbuf.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_io_txbuf.sv
// Console TX buffer: CPU-writable byte FIFO drained into the UART monitor character port,
// with optional LF -> CR-LF expansion and status/control registers.
module uart_io_txbuf #(
    parameter int unsigned DEPTH_W      = 4,
    parameter bit          CRLF_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_we,
    input  logic [1:0]  io_wadr,
    input  logic [31:0] io_wdata,
    input  logic        io_re,
    input  logic [1:0]  io_radr,
    output logic [31:0] io_rdata,
    output logic        io_busy,
    output logic [7:0]  uart_io_char,
    output logic        uart_io_we,
    input  logic        uart_io_full
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;
    localparam int unsigned CNT_W = DEPTH_W + 1;

    typedef enum logic [1:0] {IDLE, GAP, GAP_CR, LF} state_t;

    logic [7:0]         mem [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overrun;
    logic               crlf_en;
    state_t             state;
    state_t             state_n;
    logic               we_n;
    logic [7:0]         char_n;
    logic               pop;
    logic [31:0]        rdata_n;

    logic       full;
    logic       empty;
    logic [7:0] head;
    logic       push_req;
    logic       ctrl_wr;
    logic       flush;
    logic       push;
    logic       do_pop;
    logic       unused_wdata;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign push_req = io_we && (io_wadr == 2'd0);
    assign ctrl_wr  = io_we && (io_wadr == 2'd2);
    assign flush    = ctrl_wr && io_wdata[1];
    assign push     = push_req && !full;
    assign do_pop   = pop && !flush;
    assign io_busy  = full;

    assign unused_wdata = ^io_wdata[31:8];

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= io_wdata[7:0];
        end
    end

    // Pointers, occupancy and control/status bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            crlf_en <= CRLF_DEFAULT;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + DEPTH_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + DEPTH_W'(1);
                end
                if (push && !do_pop) begin
                    count <= count + CNT_W'(1);
                end else if (!push && do_pop) begin
                    count <= count - CNT_W'(1);
                end
            end
            if (push_req && full) begin
                overrun <= 1'b1;
            end else if (ctrl_wr && io_wdata[2]) begin
                overrun <= 1'b0;
            end
            if (ctrl_wr) begin
                crlf_en <= io_wdata[0];
            end
        end
    end

    // Register read mux.
    always_comb begin
        rdata_n = 32'd0;
        case (io_radr)
            2'd1:    rdata_n = {24'(count), 5'b0, overrun, empty, full};
            2'd2:    rdata_n = 32'(crlf_en);
            default: rdata_n = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_rdata <= 32'd0;
        end else if (io_re) begin
            io_rdata <= rdata_n;
        end
    end

    // Drain FSM state and registered character port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            uart_io_we   <= 1'b0;
            uart_io_char <= 8'd0;
        end else begin
            state        <= state_n;
            uart_io_we   <= we_n;
            uart_io_char <= char_n;
        end
    end

    // A flush in IDLE suppresses issue so no flushed byte leaks out.
    always_comb begin
        state_n = state;
        we_n    = 1'b0;
        char_n  = uart_io_char;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !uart_io_full && !flush) begin
                    we_n = 1'b1;
                    if (head == 8'h0A && crlf_en) begin
                        char_n  = 8'h0D;
                        state_n = GAP_CR;
                    end else begin
                        char_n  = head;
                        pop     = 1'b1;
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            GAP_CR: begin
                state_n = flush ? IDLE : LF;
            end
            LF: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (!uart_io_full) begin
                    we_n    = 1'b1;
                    char_n  = 8'h0A;
                    pop     = 1'b1;
                    state_n = GAP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
